cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Cache line refill / writeback bridge onto an AXI3 master port.
// One transaction in flight; bursts move a full line, uncached accesses move one word.
module cache_axi_bridge #(
    parameter logic        ID          = 1'b0,
    parameter int unsigned BURST_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic                      uncached,
    input  logic [31:0]               addr,
    input  logic [3:0]                wstrb_in,
    input  logic [32*BURST_WORDS-1:0] wline,
    output logic                      ready,
    output logic                      done,
    output logic [32*BURST_WORDS-1:0] rline,
    output logic                      err,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int unsigned LINE_W    = 32 * BURST_WORDS;
    localparam int unsigned OFF_W     = $clog2(BURST_WORDS * 4);
    localparam logic [31:0] LINE_MASK = ~32'((1 << OFF_W) - 1);
    localparam logic [3:0]  BURST_LEN = 4'(BURST_WORDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q;
    logic              unc_q;
    logic [3:0]        wstrb_q;
    logic [LINE_W-1:0] wline_q;
    logic [3:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              accept, r_beat, w_beat, b_hs;
    logic              src_unc;
    logic [31:0]       src_addr, ax_addr;
    logic [3:0]        src_wstrb, len_d;
    logic              err_d;
    logic [LINE_W-1:0] rline_d;
    logic [31:0]       wword_d;
    logic              unused_axi;

    // IDs, lock and prot never change for a given bridge instance.
    assign arid   = {3'b000, ID};
    assign awid   = {3'b000, ID};
    assign wid    = {3'b000, ID};
    assign arlock = 2'b00;
    assign awlock = 2'b00;
    assign arprot = {2'b00, ID};
    assign awprot = {2'b00, ID};

    assign unused_axi = ^{rid, bid, rresp[0], bresp[0]};

    // Next-state, beat counter, read-line capture and error accumulation.
    always_comb begin
        state_d   = state_q;
        accept    = req & ready;
        r_beat    = (state_q == S_R) & rvalid & rready;
        w_beat    = (state_q == S_W) & wvalid & wready;
        b_hs      = (state_q == S_B) & bvalid & bready;
        src_unc   = accept ? uncached : unc_q;
        src_addr  = accept ? addr : addr_q;
        src_wstrb = accept ? wstrb_in : wstrb_q;
        len_d     = src_unc ? 4'd0 : BURST_LEN;
        ax_addr   = src_unc ? {src_addr[31:2], 2'b00} : (src_addr & LINE_MASK);

        case (state_q)
            S_IDLE:  if (accept) state_d = we ? S_AW : S_AR;
            S_AR:    if (arvalid & arready) state_d = S_R;
            S_R:     if (r_beat & rlast) state_d = S_DONE;
            S_AW:    if (awvalid & awready) state_d = S_W;
            S_W:     if (w_beat & wlast) state_d = S_B;
            S_B:     if (b_hs) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_d  = cnt_q;
        full_d = full_q;
        if ((state_d != state_q) && ((state_d == S_R) || (state_d == S_W))) begin
            cnt_d  = 4'd0;
            full_d = 1'b0;
        end else if (r_beat | w_beat) begin
            if (cnt_q == BURST_LEN) full_d = 1'b1;
            else                    cnt_d  = cnt_q + 4'd1;
        end

        // Beats past the end of the line are accepted but dropped.
        rline_d = rline;
        if (r_beat & ~full_q) begin
            for (int unsigned i = 0; i < BURST_WORDS; i++) begin
                if (cnt_q == 4'(i)) rline_d[32*i +: 32] = rdata;
            end
        end

        wword_d = 32'd0;
        for (int unsigned i = 0; i < BURST_WORDS; i++) begin
            if (cnt_d == 4'(i)) wword_d = wline_q[32*i +: 32];
        end

        err_d = err;
        if (accept) begin
            err_d = 1'b0;
        end else begin
            if (r_beat) err_d = err_d | rresp[1];
            if (b_hs)   err_d = err_d | bresp[1];
        end
    end

    // All state and AXI outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rline   <= '0;
            addr_q  <= 32'd0;
            unc_q   <= 1'b0;
            wstrb_q <= 4'd0;
            wline_q <= '0;
            cnt_q   <= 4'd0;
            full_q  <= 1'b0;
            araddr  <= 32'd0;
            arlen   <= 4'd0;
            arsize  <= 3'd0;
            arburst <= 2'd0;
            arcache <= 4'd0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awaddr  <= 32'd0;
            awlen   <= 4'd0;
            awsize  <= 3'd0;
            awburst <= 2'd0;
            awcache <= 4'd0;
            awvalid <= 1'b0;
            wdata   <= 32'd0;
            wstrb   <= 4'd0;
            wlast   <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == S_IDLE);
            done    <= (state_d == S_DONE);
            err     <= err_d;
            rline   <= rline_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            if (accept) begin
                addr_q  <= addr;
                unc_q   <= uncached;
                wstrb_q <= wstrb_in;
                wline_q <= wline;
            end

            arvalid <= (state_d == S_AR);
            araddr  <= (state_d == S_AR) ? ax_addr : 32'd0;
            arlen   <= (state_d == S_AR) ? len_d : 4'd0;
            arsize  <= (state_d == S_AR) ? 3'b010 : 3'b000;
            arburst <= (state_d == S_AR) ? (src_unc ? 2'b00 : 2'b01) : 2'b00;
            arcache <= (state_d == S_AR) ? (src_unc ? 4'h0 : 4'hF) : 4'h0;
            rready  <= (state_d == S_R);

            awvalid <= (state_d == S_AW);
            awaddr  <= (state_d == S_AW) ? ax_addr : 32'd0;
            awlen   <= (state_d == S_AW) ? len_d : 4'd0;
            awsize  <= (state_d == S_AW) ? 3'b010 : 3'b000;
            awburst <= (state_d == S_AW) ? (src_unc ? 2'b00 : 2'b01) : 2'b00;
            awcache <= (state_d == S_AW) ? (src_unc ? 4'h0 : 4'hF) : 4'h0;

            wvalid  <= (state_d == S_W);
            wdata   <= (state_d == S_W) ? wword_d : 32'd0;
            wstrb   <= (state_d == S_W) ? (src_unc ? src_wstrb : 4'hF) : 4'h0;
            wlast   <= (state_d == S_W) && (cnt_d == len_d);
            bready  <= (state_d == S_B);
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: a 16-word instance driven through reads,
// writes, errors and a mid-burst reset, plus a 1-word instance.
module tb_cache_axi_bridge;

    localparam int unsigned BW = 16;
    localparam int unsigned LW = 32 * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req, we, uncached;
    logic [31:0]   addr;
    logic [3:0]    wstrb_in;
    logic [LW-1:0] wline;
    logic          ready, done, err;
    logic [LW-1:0] rline;
    logic [3:0]    arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0]   araddr, awaddr, wdata, rdata;
    logic [2:0]    arsize, arprot, awsize, awprot;
    logic [1:0]    arburst, arlock, awburst, awlock, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic          u1_req, u1_ready, u1_done, u1_err;
    logic [31:0]   u1_addr, u1_rline, u1_rdata, u1_araddr, u1_awaddr, u1_wdata;
    logic [3:0]    u1_arid, u1_arlen, u1_arcache, u1_awid, u1_awlen, u1_awcache, u1_wid, u1_wstrb;
    logic [2:0]    u1_arsize, u1_arprot, u1_awsize, u1_awprot;
    logic [1:0]    u1_arburst, u1_arlock, u1_awburst, u1_awlock;
    logic          u1_arvalid, u1_arready, u1_rlast, u1_rvalid, u1_rready;
    logic          u1_awvalid, u1_wlast, u1_wvalid, u1_bready;

    typedef struct packed { logic [LW-1:0] line; logic err; } rexp_t;
    typedef struct packed { logic [31:0] data; logic last; logic [3:0] strb; } wexp_t;

    rexp_t         rq[$];
    wexp_t         wq[$];
    logic [LW-1:0] model_line;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    cache_axi_bridge #(.ID(1'b0), .BURST_WORDS(BW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .uncached(uncached), .addr(addr),
        .wstrb_in(wstrb_in), .wline(wline), .ready(ready), .done(done), .rline(rline), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(4'd0), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(4'd0), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    cache_axi_bridge #(.ID(1'b1), .BURST_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .req(u1_req), .we(1'b0), .uncached(1'b0), .addr(u1_addr),
        .wstrb_in(4'h0), .wline(32'd0), .ready(u1_ready), .done(u1_done), .rline(u1_rline), .err(u1_err),
        .arid(u1_arid), .araddr(u1_araddr), .arlen(u1_arlen), .arsize(u1_arsize), .arburst(u1_arburst),
        .arlock(u1_arlock), .arcache(u1_arcache), .arprot(u1_arprot), .arvalid(u1_arvalid),
        .arready(u1_arready), .rid(4'd0), .rdata(u1_rdata), .rresp(2'b00), .rlast(u1_rlast),
        .rvalid(u1_rvalid), .rready(u1_rready),
        .awid(u1_awid), .awaddr(u1_awaddr), .awlen(u1_awlen), .awsize(u1_awsize), .awburst(u1_awburst),
        .awlock(u1_awlock), .awcache(u1_awcache), .awprot(u1_awprot), .awvalid(u1_awvalid),
        .awready(1'b0), .wid(u1_wid), .wdata(u1_wdata), .wstrb(u1_wstrb), .wlast(u1_wlast),
        .wvalid(u1_wvalid), .wready(1'b0), .bid(4'd0), .bresp(2'b00), .bvalid(1'b0), .bready(u1_bready)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read transaction; abort_beat >= 0 pulses reset while that beat is on the bus.
    task automatic axi_read(input logic [31:0] a, input logic unc, input logic [31:0] exp_addr,
                            input int nbeats, input logic [31:0] base, input int err_beat,
                            input int ar_delay, input int abort_beat);
        rexp_t e;
        int    k;
        for (int i = 0; i < nbeats && i < int'(BW); i++) model_line[32*i +: 32] = base + 32'(i);
        e.line = model_line;
        e.err  = (err_beat >= 0) && (err_beat < nbeats);
        rq.push_back(e);

        req = 1'b1; we = 1'b0; uncached = unc; addr = a;
        @(negedge clk);
        req = 1'b0;
        check("ar_valid", arvalid, 1'b1);
        check("ar_addr", araddr, exp_addr);
        check("ar_len", arlen, unc ? 4'd0 : 4'd15);
        check("ar_burst", arburst, unc ? 2'b00 : 2'b01);
        check("ar_cache", arcache, unc ? 4'h0 : 4'hF);
        check("ar_size", arsize, 3'b010);
        check("ar_id_prot", {arid, arprot}, 7'd0);
        check("ready_busy", ready, 1'b0);
        repeat (ar_delay) @(negedge clk);
        if (ar_delay > 0) check("ar_hold", arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("ar_drop", arvalid, 1'b0);
        check("ar_addr_idle", araddr, 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            check("r_ready", rready, 1'b1);
            rvalid = 1'b1;
            rdata  = base + 32'(i);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == nbeats - 1);
            if (i == abort_beat) begin
                #2 rst = 1'b1;
                #1;
                check("rst_rready", rready, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_err", err, 1'b0);
                check("rst_rline", rline, '0);
                @(negedge clk);
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rst = 1'b0;
                @(negedge clk);
                check("rst_ready", ready, 1'b1);
                check("rst_no_done", done, 1'b0);
                void'(rq.pop_back());
                model_line = '0;
                return;
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        k = 0;
        while (done !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("rd_latency", k, 0);
        e = rq.pop_front();
        check("rd_line", rline, e.line);
        check("rd_err", err, e.err);
        @(negedge clk);
        check("rd_done_pulse", done, 1'b0);
        check("rd_ready_back", ready, 1'b1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic unc, input logic [3:0] strb,
                             input logic [31:0] exp_addr, input int aw_delay, input logic toggle,
                             input logic [1:0] br);
        wexp_t e;
        int    n;
        int    c;
        logic  seen_last;
        n = unc ? 1 : int'(BW);
        for (int i = 0; i < n; i++) begin
            e.data = wline[32*i +: 32];
            e.last = (i == n - 1);
            e.strb = unc ? strb : 4'hF;
            wq.push_back(e);
        end

        req = 1'b1; we = 1'b1; uncached = unc; addr = a; wstrb_in = strb;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("aw_valid", awvalid, 1'b1);
        check("aw_addr", awaddr, exp_addr);
        check("aw_len", awlen, unc ? 4'd0 : 4'd15);
        check("aw_burst", awburst, unc ? 2'b00 : 2'b01);
        check("aw_cache", awcache, unc ? 4'h0 : 4'hF);
        check("aw_size", awsize, 3'b010);
        check("w_valid_early", wvalid, 1'b0);
        repeat (aw_delay) @(negedge clk);
        if (aw_delay > 0) check("aw_hold", awvalid, 1'b1);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("aw_drop", awvalid, 1'b0);
        check("aw_addr_idle", awaddr, 32'd0);
        seen_last = 1'b0;
        c = 0;
        while (!seen_last && c < 200) begin
            wready = toggle ? (c % 2 == 1) : 1'b1;
            if (wvalid === 1'b1 && wready) begin
                check("w_queue", wq.size() != 0, 1'b1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("w_data", wdata, e.data);
                    check("w_last", wlast, e.last);
                    check("w_strb", wstrb, e.strb);
                    seen_last = e.last;
                end
            end
            @(negedge clk);
            c++;
        end
        wready = 1'b0;
        check("w_complete", seen_last, 1'b1);
        check("w_leftover", wq.size(), 0);
        check("w_valid_drop", wvalid, 1'b0);
        check("b_ready", bready, 1'b1);
        bvalid = 1'b1; bresp = br;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        check("wr_done", done, 1'b1);
        check("wr_err", err, br[1]);
        @(negedge clk);
        check("wr_done_pulse", done, 1'b0);
        check("wr_ready_back", ready, 1'b1);
    endtask

    initial begin
        req = 0; we = 0; uncached = 0; addr = 0; wstrb_in = 0; wline = '0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        u1_req = 0; u1_addr = 0; u1_arready = 0; u1_rdata = 0; u1_rlast = 0; u1_rvalid = 0;
        model_line = '0;

        repeat (2) @(negedge clk);
        check("rst_done0", done, 1'b0);
        check("rst_err0", err, 1'b0);
        check("rst_valids", {arvalid, awvalid, wvalid, wlast, rready, bready}, 6'd0);
        check("rst_rline0", rline, '0);
        check("rst_araddr", araddr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1'b1);

        axi_read(32'h1000_0044, 1'b0, 32'h1000_0040, 16, 32'h0, -1, 0, -1);

        for (int i = 0; i < int'(BW); i++) wline[32*i +: 32] = 32'hA0 + 32'(i);
        axi_write(32'h1000_0088, 1'b0, 4'h0, 32'h1000_0080, 3, 1'b1, 2'b00);

        wline = {BW{32'h5555_5555}};
        wline[31:0] = 32'hDEAD_BEEF;
        axi_write(32'hBFAF_F002, 1'b1, 4'b0100, 32'hBFAF_F000, 0, 1'b0, 2'b00);
        axi_write(32'h0000_1234, 1'b1, 4'b1111, 32'h0000_1234, 1, 1'b0, 2'b10);

        axi_read(32'h2000_0010, 1'b0, 32'h2000_0000, 16, 32'h100, 5, 2, -1);
        axi_read(32'h2000_0050, 1'b0, 32'h2000_0040, 16, 32'h200, -1, 0, -1);
        axi_read(32'h2000_00FC, 1'b0, 32'h2000_00C0, 4, 32'h300, -1, 0, -1);
        axi_read(32'h2000_0100, 1'b0, 32'h2000_0100, 18, 32'h400, -1, 1, -1);
        axi_read(32'h2000_0007, 1'b1, 32'h2000_0004, 1, 32'h77, -1, 0, -1);
        axi_read(32'h3000_0000, 1'b0, 32'h3000_0000, 16, 32'h600, -1, 0, 7);
        axi_read(32'h3000_0040, 1'b0, 32'h3000_0040, 16, 32'h700, -1, 0, -1);

        u1_req = 1'b1; u1_addr = 32'h3000_0046;
        @(negedge clk);
        u1_req = 1'b0;
        check("u1_ar_valid", u1_arvalid, 1'b1);
        check("u1_ar_addr", u1_araddr, 32'h3000_0044);
        check("u1_ar_len", u1_arlen, 4'd0);
        check("u1_ar_burst", u1_arburst, 2'b01);
        check("u1_ar_id", u1_arid, 4'b0001);
        check("u1_ar_prot", u1_arprot, 3'b001);
        u1_arready = 1'b1;
        @(negedge clk);
        u1_arready = 1'b0;
        check("u1_r_ready", u1_rready, 1'b1);
        u1_rvalid = 1'b1; u1_rdata = 32'hCAFE_F00D; u1_rlast = 1'b1;
        @(negedge clk);
        u1_rvalid = 1'b0; u1_rlast = 1'b0;
        check("u1_done", u1_done, 1'b1);
        check("u1_rline", u1_rline, 32'hCAFE_F00D);
        check("u1_err", u1_err, 1'b0);
        @(negedge clk);
        check("u1_ready_back", u1_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
